// File: rtl/flappy_game_if.sv
// Renderer-configuration bus of the flappy game controller: frame tick and flap in,
// screen/scroll/bird/score/pipe configuration out.
interface flappy_game_if;
    logic               frame_tick;
    logic               flap;
    logic [1:0]         screen;
    logic               bg_scroll;
    logic signed [16:0] bird_y;
    logic [15:0]        score;
    logic signed [16:0] pipe1_x;
    logic signed [16:0] pipe2_x;
    logic signed [16:0] pipe3_x;
    logic signed [16:0] pipe1_y;
    logic signed [16:0] pipe2_y;
    logic signed [16:0] pipe3_y;

    // Controller side: consumes tick/flap, drives the renderer configuration.
    modport master (
        input  frame_tick, flap,
        output screen, bg_scroll, bird_y, score,
        output pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y
    );

    // Environment side: timing/debouncer drive tick/flap, renderer reads the rest.
    modport slave (
        output frame_tick, flap,
        input  screen, bg_scroll, bird_y, score,
        input  pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y
    );
endinterface

// File: rtl/flappy_game_controller.sv
// Flappy game sequencer: title/play/game-over FSM with per-frame bird physics, pipe motion
// and recycling, scoring and collision. Define GAME_SPEED_RAMP_EN for score-based pipe speed-up.
module flappy_game_controller #(
    parameter int          SCREEN_WIDTH         = 640,
    parameter int          SCREEN_HEIGHT        = 480,
    parameter int          BIRD_X               = 303,
    parameter int          BIRD_WIDTH           = 34,
    parameter int          BIRD_HEIGHT          = 24,
    parameter int          BIRD_START_Y         = 228,
    parameter int          PIPE_WIDTH           = 52,
    parameter int          PIPE_GAP             = 100,
    parameter int          PIPE_SPACING         = 240,
    parameter int          PIPE_SPEED           = 2,
    parameter int          PIPE_Y_INIT          = 140,
    parameter int          PIPE_Y_MIN           = 40,
    parameter int          PIPE_Y_RAND_BITS     = 8,
    parameter int          GRAVITY              = 1,
    parameter int          FLAP_VELOCITY        = -8,
    parameter int          MAX_FALL             = 10,
    parameter int          GAMEOVER_HOLD_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input logic           iClock,
    input logic           iReset,
    flappy_game_if.master bus
);
    typedef logic signed [16:0] pos_t;
    typedef enum logic [1:0] {StTitle = 2'd0, StPlay = 2'd1, StGameOver = 2'd2} state_e;

    localparam pos_t               Zero       = pos_t'(0);
    localparam pos_t               ScreenH    = pos_t'(SCREEN_HEIGHT);
    localparam pos_t               BirdX      = pos_t'(BIRD_X);
    localparam pos_t               BirdW      = pos_t'(BIRD_WIDTH);
    localparam pos_t               BirdH      = pos_t'(BIRD_HEIGHT);
    localparam pos_t               BirdStartY = pos_t'(BIRD_START_Y);
    localparam pos_t               BirdYMax   = pos_t'(SCREEN_HEIGHT - BIRD_HEIGHT);
    localparam pos_t               PipeW      = pos_t'(PIPE_WIDTH);
    localparam pos_t               PipeGap    = pos_t'(PIPE_GAP);
    localparam pos_t               PipeWrap   = pos_t'(3 * PIPE_SPACING);
    localparam pos_t               PipeSpeed  = pos_t'(PIPE_SPEED);
    localparam pos_t               PipeX0     = pos_t'(SCREEN_WIDTH);
    localparam pos_t               PipeYInit  = pos_t'(PIPE_Y_INIT);
    localparam pos_t               PipeYMin   = pos_t'(PIPE_Y_MIN);
    localparam pos_t               Gravity    = pos_t'(GRAVITY);
    localparam pos_t               MaxFall    = pos_t'(MAX_FALL);
    localparam logic signed [7:0]  FlapVel8   = 8'(FLAP_VELOCITY);
    localparam logic signed [7:0]  MaxFall8   = 8'(MAX_FALL);
    localparam logic [15:0]        HoldInit   = 16'(GAMEOVER_HOLD_FRAMES);
    localparam logic [15:0]        ScoreMax   = 16'd999;
    localparam logic [15:0]        LfsrMask   = 16'hB400;

    state_e             state_q, state_d;
    logic               bg_q, bg_d;
    pos_t               bird_y_q, bird_y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [15:0]        score_q, score_d;
    pos_t               pipe_x_q [3];
    pos_t               pipe_x_d [3];
    pos_t               pipe_y_q [3];
    pos_t               pipe_y_d [3];
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               flap_q, pend_q, pend_d;

    logic               flap_now, hit, reinit;
    pos_t               vel_sum, bird_n, speed;
    logic signed [7:0]  vel_n;
    pos_t               x_n [3];
    pos_t               y_n [3];
    logic [1:0]         n_pass;
    logic [15:0]        score_sum;

    always_comb begin
        // A flap edge landing on the tick cycle belongs to that tick.
        flap_now = pend_q | (bus.flap & ~flap_q);
        pend_d   = flap_now & ~bus.frame_tick;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

        vel_sum = pos_t'(vel_q) + Gravity;
        if (flap_now)               vel_n = FlapVel8;
        else if (vel_sum > MaxFall) vel_n = MaxFall8;
        else                        vel_n = vel_sum[7:0];
        bird_n = bird_y_q + pos_t'(vel_n);

`ifdef GAME_SPEED_RAMP_EN
        // min(score/10, 2) needs only two threshold compares, not a divider.
        if (score_q >= 16'd20)      speed = PipeSpeed + pos_t'(2);
        else if (score_q >= 16'd10) speed = PipeSpeed + pos_t'(1);
        else                        speed = PipeSpeed;
`else
        speed = PipeSpeed;
`endif

        n_pass = 2'd0;
        hit    = (bird_n < Zero) || (bird_n + BirdH > ScreenH);
        for (int i = 0; i < 3; i++) begin
            x_n[i] = pipe_x_q[i] - speed;
            y_n[i] = pipe_y_q[i];
            if (x_n[i] < -PipeW) begin
                x_n[i] = x_n[i] + PipeWrap;
                y_n[i] = PipeYMin + pos_t'(lfsr_q[PIPE_Y_RAND_BITS-1:0]);
            end
            if ((pipe_x_q[i] + PipeW > BirdX) && (x_n[i] + PipeW <= BirdX)) begin
                n_pass = n_pass + 2'd1;
            end
            if ((x_n[i] < BirdX + BirdW) && (x_n[i] + PipeW > BirdX) &&
                ((bird_n < y_n[i]) || (bird_n + BirdH > y_n[i] + PipeGap))) begin
                hit = 1'b1;
            end
        end
        score_sum = score_q + 16'(n_pass);

        state_d  = state_q;
        bg_d     = bg_q;
        bird_y_d = bird_y_q;
        vel_d    = vel_q;
        score_d  = score_q;
        pipe_x_d = pipe_x_q;
        pipe_y_d = pipe_y_q;
        hold_d   = hold_q;
        reinit   = 1'b0;

        if (bus.frame_tick) begin
            unique case (state_q)
                StTitle: begin
                    if (flap_now) begin
                        state_d = StPlay;
                        vel_d   = FlapVel8;
                        score_d = 16'd0;
                    end
                end
                StPlay: begin
                    vel_d    = vel_n;
                    bird_y_d = bird_n;
                    pipe_x_d = x_n;
                    pipe_y_d = y_n;
                    score_d  = (score_sum > ScoreMax) ? ScoreMax : score_sum;
                    if (hit) begin
                        state_d = StGameOver;
                        hold_d  = HoldInit;
                        bg_d    = 1'b0;
                        if (bird_n < Zero)          bird_y_d = Zero;
                        else if (bird_n > BirdYMax) bird_y_d = BirdYMax;
                    end
                end
                StGameOver: begin
                    if (hold_q != 16'd0) hold_d = hold_q - 16'd1;
                    else if (flap_now)   reinit = 1'b1;
                end
                default: state_d = StTitle;
            endcase
        end
    end

    // LFSR and flap edge tracking survive the game-over reinit.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            lfsr_q <= LFSR_SEED;
            flap_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            flap_q <= bus.flap;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset || reinit) begin
            state_q  <= StTitle;
            bg_q     <= 1'b1;
            bird_y_q <= BirdStartY;
            vel_q    <= 8'sd0;
            score_q  <= 16'd0;
            hold_q   <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                pipe_x_q[i] <= PipeX0 + pos_t'(i * PIPE_SPACING);
                pipe_y_q[i] <= PipeYInit;
            end
        end else begin
            state_q  <= state_d;
            bg_q     <= bg_d;
            bird_y_q <= bird_y_d;
            vel_q    <= vel_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
            pipe_x_q <= pipe_x_d;
            pipe_y_q <= pipe_y_d;
        end
    end

    assign bus.screen    = state_q;
    assign bus.bg_scroll = bg_q;
    assign bus.bird_y    = bird_y_q;
    assign bus.score     = score_q;
    assign bus.pipe1_x   = pipe_x_q[0];
    assign bus.pipe2_x   = pipe_x_q[1];
    assign bus.pipe3_x   = pipe_x_q[2];
    assign bus.pipe1_y   = pipe_y_q[0];
    assign bus.pipe2_y   = pipe_y_q[1];
    assign bus.pipe3_y   = pipe_y_q[2];
endmodule

// File: tb/tb_flappy_game_controller.sv
// Bench for flappy_game_controller: directed game-flow checks plus random flap/tick traffic
// on a default and a zero-gravity instance, both compared to a frame-level behavioural model.
module tb_flappy_game_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flappy_game_if bus_a ();
    flappy_game_if bus_b ();

    flappy_game_controller dut_a (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus_a)
    );

    flappy_game_controller #(
        .GRAVITY          (0),
        .FLAP_VELOCITY    (0),
        .PIPE_Y_INIT      (180),
        .PIPE_Y_MIN       (160),
        .PIPE_Y_RAND_BITS (6)
    ) dut_b (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus_b)
    );

    // Model state per instance (0 = default, 1 = override).
    int m_screen [2], m_bird [2], m_vel [2], m_score [2], m_hold [2], m_bg [2];
    int m_px [2][3], m_py [2][3];
    int cfg_g [2], cfg_fv [2], cfg_yi [2], cfg_ymin [2], cfg_bits [2];
    int m_lfsr;
    bit m_pend, m_prev;
    int n_checks, n_errors, b_play_ticks;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_init(input int k);
        m_screen[k] = 0;
        m_bg[k]     = 1;
        m_bird[k]   = 228;
        m_vel[k]    = 0;
        m_score[k]  = 0;
        m_hold[k]   = 0;
        for (int i = 0; i < 3; i++) begin
            m_px[k][i] = 640 + 240 * i;
            m_py[k][i] = cfg_yi[k];
        end
    endtask

    task automatic model_tick(input int k, input bit fl);
        int spd, passed, oldx, nx;
        bit hit;
        case (m_screen[k])
            0: begin
                if (fl) begin
                    m_screen[k] = 1;
                    m_vel[k]    = cfg_fv[k];
                    m_score[k]  = 0;
                end
            end
            1: begin
                if (fl) m_vel[k] = cfg_fv[k];
                else    m_vel[k] = (m_vel[k] + cfg_g[k] > 10) ? 10 : m_vel[k] + cfg_g[k];
                m_bird[k] += m_vel[k];
                spd = 2;
`ifdef GAME_SPEED_RAMP_EN
                spd += (m_score[k] / 10 > 2) ? 2 : m_score[k] / 10;
`endif
                passed = 0;
                hit = (m_bird[k] < 0) || (m_bird[k] + 24 > 480);
                for (int i = 0; i < 3; i++) begin
                    oldx = m_px[k][i];
                    nx   = oldx - spd;
                    if (nx < -52) begin
                        nx += 720;
                        m_py[k][i] = cfg_ymin[k] + (m_lfsr % (1 << cfg_bits[k]));
                    end
                    m_px[k][i] = nx;
                    if (oldx + 52 > 303 && nx + 52 <= 303) passed++;
                    if (nx < 337 && nx + 52 > 303 &&
                        (m_bird[k] < m_py[k][i] || m_bird[k] + 24 > m_py[k][i] + 100)) hit = 1;
                end
                m_score[k] = (m_score[k] + passed > 999) ? 999 : m_score[k] + passed;
                if (hit) begin
                    if (m_bird[k] < 0)   m_bird[k] = 0;
                    if (m_bird[k] > 456) m_bird[k] = 456;
                    m_screen[k] = 2;
                    m_hold[k]   = 60;
                    m_bg[k]     = 0;
                end
            end
            default: begin
                if (m_hold[k] > 0) m_hold[k]--;
                else if (fl)       model_init(k);
            end
        endcase
    endtask

    task automatic cmp_outs(input int k, input string nm, input logic [1:0] scr, input logic bg,
                            input logic signed [16:0] by, input logic [15:0] sc,
                            input logic signed [16:0] x0, x1, x2, y0, y1, y2);
        check_eq({nm, ".screen"}, scr, m_screen[k]);
        check_eq({nm, ".bg"}, bg, m_bg[k]);
        check_eq({nm, ".bird_y"}, by, m_bird[k]);
        check_eq({nm, ".score"}, sc, m_score[k]);
        check_eq({nm, ".p1x"}, x0, m_px[k][0]);
        check_eq({nm, ".p2x"}, x1, m_px[k][1]);
        check_eq({nm, ".p3x"}, x2, m_px[k][2]);
        check_eq({nm, ".p1y"}, y0, m_py[k][0]);
        check_eq({nm, ".p2y"}, y1, m_py[k][1]);
        check_eq({nm, ".p3y"}, y2, m_py[k][2]);
    endtask

    // One clock: drive inputs, advance the model with what the DUT saw, then compare.
    task automatic step(input bit tick, input bit fl, input bit r);
        bit fnow;
        bus_a.frame_tick = tick;
        bus_b.frame_tick = tick;
        bus_a.flap       = fl;
        bus_b.flap       = fl;
        rst              = r;
        @(posedge clk);
        if (r) begin
            model_init(0);
            model_init(1);
            m_lfsr = 'hACE1;
            m_pend = 0;
            m_prev = 0;
        end else begin
            fnow = m_pend || (fl && !m_prev);
            if (tick) begin
                if (m_screen[1] == 1) b_play_ticks++;
                model_tick(0, fnow);
                model_tick(1, fnow);
                m_pend = 0;
            end else begin
                m_pend = fnow;
            end
            m_prev = fl;
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        end
        #1;
        cmp_outs(0, "a", bus_a.screen, bus_a.bg_scroll, bus_a.bird_y, bus_a.score,
                 bus_a.pipe1_x, bus_a.pipe2_x, bus_a.pipe3_x,
                 bus_a.pipe1_y, bus_a.pipe2_y, bus_a.pipe3_y);
        cmp_outs(1, "b", bus_b.screen, bus_b.bg_scroll, bus_b.bird_y, bus_b.score,
                 bus_b.pipe1_x, bus_b.pipe2_x, bus_b.pipe3_x,
                 bus_b.pipe1_y, bus_b.pipe2_y, bus_b.pipe3_y);
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, ".screen"}, bus_a.screen, 0);
        check_eq({tag, ".bg"}, bus_a.bg_scroll, 1);
        check_eq({tag, ".bird_y"}, bus_a.bird_y, 228);
        check_eq({tag, ".score"}, bus_a.score, 0);
        check_eq({tag, ".p1x"}, bus_a.pipe1_x, 640);
        check_eq({tag, ".p2x"}, bus_a.pipe2_x, 880);
        check_eq({tag, ".p3x"}, bus_a.pipe3_x, 1120);
        check_eq({tag, ".p1y"}, bus_a.pipe1_y, 140);
        check_eq({tag, ".p2y"}, bus_a.pipe2_y, 140);
        check_eq({tag, ".p3y"}, bus_a.pipe3_y, 140);
    endtask

    initial begin
        int guard, gap, prev_ticks, maxd, d;
        logic signed [16:0] prev_y;
        bit fl;
`ifdef GAME_SPEED_RAMP_EN
        logic signed [16:0] ramp_x;
        bit ramp_pend, ramp_done;
        ramp_pend = 0;
        ramp_done = 0;
`endif
        cfg_g    = '{1, 0};
        cfg_fv   = '{-8, 0};
        cfg_yi   = '{140, 180};
        cfg_ymin = '{40, 160};
        cfg_bits = '{8, 6};
        n_checks = 0;
        n_errors = 0;
        b_play_ticks = 0;
        m_lfsr = 'hACE1;

        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check_reset_a("rst");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
            check_reset_a("title_idle");
        end

        step(1, 1, 0);
        check_eq("a.start_screen", bus_a.screen, 1);
        check_eq("a.start_bird", bus_a.bird_y, 228);
        step(0, 0, 0);
        step(1, 0, 0);
        check_eq("a.bird_221", bus_a.bird_y, 221);
        step(1, 0, 0);
        check_eq("a.bird_215", bus_a.bird_y, 215);

        // Free fall: fastest per-frame drop before impact must be the saturated velocity.
        guard = 0;
        maxd  = 0;
        while (bus_a.screen != 2 && guard < 200) begin
            prev_y = bus_a.bird_y;
            step(1, 0, 0);
            d = bus_a.bird_y - prev_y;
            if (bus_a.screen == 1 && d > maxd) maxd = d;
            guard++;
        end
        check_eq("a.max_fall", maxd, 10);
        check_eq("a.ground_screen", bus_a.screen, 2);
        check_eq("a.ground_bird", bus_a.bird_y, 456);
        check_eq("a.ground_bg", bus_a.bg_scroll, 0);
        check_eq("a.ground_score", bus_a.score, 0);

        for (int i = 1; i <= 60; i++) begin
            step(1, 1, 0);
            check_eq("a.hold_screen", bus_a.screen, 2);
            step(0, 0, 0);
        end
        step(1, 1, 0);
        check_reset_a("restart");

        guard = 0;
        while (b_play_ticks < 1400 && guard < 5000) begin
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) step(0, 1'($urandom_range(0, 1)), 0);
            fl = ($urandom_range(0, 3) == 0);
`ifdef GAME_SPEED_RAMP_EN
            if (!ramp_done && bus_b.screen == 1 && bus_b.score >= 10 && bus_b.score < 20 &&
                bus_b.pipe1_x > 100) begin
                ramp_x    = bus_b.pipe1_x;
                ramp_pend = 1;
            end
`endif
            prev_ticks = b_play_ticks;
            step(1, fl, 0);
`ifdef GAME_SPEED_RAMP_EN
            if (ramp_pend) begin
                check_eq("b.ramp_dx", ramp_x - bus_b.pipe1_x, 3);
                ramp_pend = 0;
                ramp_done = 1;
            end
`endif
            if (b_play_ticks != prev_ticks && b_play_ticks == 195) begin
                check_eq("b.t195_p1x", bus_b.pipe1_x, 250);
                check_eq("b.t195_score", bus_b.score, 1);
            end
`ifndef GAME_SPEED_RAMP_EN
            if (b_play_ticks != prev_ticks && b_play_ticks == 347) begin
                check_eq("b.t347_p1x", bus_b.pipe1_x, 666);
                check_eq("b.t347_p1y_range",
                         (bus_b.pipe1_y >= 160 && bus_b.pipe1_y <= 223) ? 1 : 0, 1);
            end
`endif
            if (b_play_ticks != prev_ticks && b_play_ticks == 500) begin
                check_eq("b.t500_screen", bus_b.screen, 1);
            end
            guard++;
        end
        check_eq("b.play_ticks", b_play_ticks, 1400);
        check_eq("b.no_gameover", bus_b.screen, 1);
`ifdef GAME_SPEED_RAMP_EN
        check_eq("b.ramp_seen", ramp_done, 1);
`endif

        step(0, 0, 1);
        check_reset_a("rst2");
        step(1, 1, 0);
        check_eq("a.replay_screen", bus_a.screen, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check_reset_a("rst_midplay");
        check_eq("b.rst_midplay_screen", bus_b.screen, 0);
        check_eq("b.rst_midplay_p1y", bus_b.pipe1_y, 180);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/flappy_game_controller.md
Name: flappy_game_controller

Overview:
Game-logic sequencer that drives the frame renderer's configuration inputs: screen select, background scroll enable, bird Y, score, and three pipe X/Y pairs. Runs the title/play/game-over state machine. Once per video frame it updates bird physics and pipe motion, recycles pipes with pseudo-random gap heights, counts score and detects collisions. Sits between the input debouncer/VGA timing and the render controller.

Parameters:
SCREEN_WIDTH, 640, visible width in pixels
SCREEN_HEIGHT, 480, visible height in pixels
BIRD_X, 303, fixed bird left edge (320 - 34/2)
BIRD_WIDTH, 34, bird sprite width
BIRD_HEIGHT, 24, bird sprite height
BIRD_START_Y, 228, bird Y on title screen and at reset
PIPE_WIDTH, 52, pipe sprite width
PIPE_GAP, 100, vertical gap between top and bottom pipe
PIPE_SPACING, 240, horizontal distance between consecutive pipes
PIPE_SPEED, 2, pixels pipes move left per frame
PIPE_Y_INIT, 140, pipe gap top at reset/title
PIPE_Y_MIN, 40, minimum randomized gap top
PIPE_Y_RAND_BITS, 8, LFSR bits added to PIPE_Y_MIN
GRAVITY, 1, velocity increment per frame
FLAP_VELOCITY, -8, velocity loaded on flap (signed)
MAX_FALL, 10, velocity saturation
GAMEOVER_HOLD_FRAMES, 60, frames flaps are ignored after death
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous active-high reset
iFrameTick  in  1  one-cycle pulse per frame (pixel address 0)
iFlap  in  1  debounced flap button, level
oScreen  out  2  0=title, 1=play, 2=game over
oBGScroll  out  1  background scroll enable
oBirdY  out  17 signed  bird top edge
oScore  out  16  score, 0..999
oPipe1X/oPipe2X/oPipe3X  out  17 signed each  pipe left edges
oPipe1Y/oPipe2Y/oPipe3Y  out  17 signed each  gap top edges

Behaviour:
- Reset (synchronous, iReset and iClock decided as above): state TITLE, oScreen=0, oBGScroll=1, oBirdY=228, velocity=0, oScore=0, pipe X = 640/880/1120, all pipe Y=140, LFSR=seed, hold=0, flap_pending=0. Reset wins over every other event, including mid-PLAY.
- LFSR: 16-bit Galois (mask 16'hB400), steps every clock regardless of state.
- Flap: rising edge of iFlap sets flap_pending. flap_pending clears on every iFrameTick. An edge coincident with a tick is counted for that tick.
- All state updates occur only on iFrameTick. Outputs are registered and valid the cycle after the tick.
- TITLE: outputs hold their initial values. On tick with flap pending -> PLAY, velocity=FLAP_VELOCITY, score=0. No motion on that tick.
- PLAY, per tick:
  - vel_n = FLAP_VELOCITY if flap pending, else min(vel+GRAVITY, MAX_FALL).
  - birdY_n = birdY + vel_n.
  - Each pipe: X_n = X - speed. If X_n < -PIPE_WIDTH, X_n += 3*PIPE_SPACING and Y_n = PIPE_Y_MIN + LFSR[PIPE_Y_RAND_BITS-1:0].
  - Score +1 per pipe with X+PIPE_WIDTH > BIRD_X and X_n+PIPE_WIDTH <= BIRD_X. Saturates at 999.
- Collision, evaluated on the new values:
  - Bird out of bounds: birdY_n < 0 or birdY_n+BIRD_HEIGHT > SCREEN_HEIGHT.
  - Pipe hit: any pipe with X_n < BIRD_X+BIRD_WIDTH and X_n+PIPE_WIDTH > BIRD_X, and (birdY_n < Y_n or birdY_n+BIRD_HEIGHT > Y_n+PIPE_GAP).
  - On collision: commit all updates with bird Y clamped to [0, SCREEN_HEIGHT-BIRD_HEIGHT]. A score increment on the same tick still counts. -> GAME_OVER, hold=GAMEOVER_HOLD_FRAMES, oBGScroll=0.
- GAME_OVER: positions and score frozen. hold decrements per tick to 0. On a tick where hold==0 and a flap is pending -> TITLE with full reinit (same values as reset, except LFSR continues); oBGScroll=1. Flaps while hold>0 are discarded.
- Arithmetic: signed 17-bit for positions, signed 8-bit velocity sign-extended. Score compare uses old and new X so that any speed is handled.

Optional Feature:
GAME_SPEED_RAMP_EN
- Defined: pipe speed = PIPE_SPEED + min(score/10, 2), sampled from the score before the tick.
- Undefined: speed is constant PIPE_SPEED, and no divider is synthesized.

Test Plan:
- Reset -> oScreen=0, oBirdY=228, X=640/880/1120, Y=140, oScore=0, oBGScroll=1, unchanged across 5 ticks without flap.
- Flap then tick -> oScreen=1. Next tick, no flap -> oBirdY=221 (vel -7). Next -> 215.
- Play with no flaps -> velocity saturates at 10. On ground hit oScreen=2, oBirdY=456, oBGScroll=0, score 0.
- Override GRAVITY=0, FLAP_VELOCITY=0, PIPE_Y_INIT=180, PIPE_Y_MIN=160, PIPE_Y_RAND_BITS=6, 500 ticks:
  - tick 195: pipe1 X=250, oScore=1.
  - tick 347: pipe1 X=666, Y in 160..223.
  - No game over.
- After death: flaps on ticks 1..60 ignored, oScreen stays 2. Flap at tick 61 -> oScreen=0, all reset values restored. iReset asserted mid-PLAY -> reset values next cycle.
- GAME_SPEED_RAMP_EN defined, same override as the pipe test: after oScore reaches 10, pipe X decreases by 3 per tick.
